usb_ctrl_ep0: RTL and testbench
===============================

Name: usb_ctrl_ep0

Overview:
Parametrised endpoint-0 control-transfer engine that sits between the usbcorev `usb` core and an external descriptor ROM.
- Captures 8-byte SETUP packets and decodes standard requests.
- Sources multi-packet IN data stages with correct DATA0/DATA1 toggling, wLength truncation and zero-length-packet (ZLP) termination.
- Runs status stages, applies SET_ADDRESS after its status stage, and latches SET_CONFIGURATION.
- Replaces the ad-hoc single-descriptor state machine in top-level logic.

Parameters:
MAX_PKT, 64, ep0 max packet size in bytes (8/16/32/64).
ADDR_W, 7, descriptor ROM address width.
DEV_OFS, 0, ROM offset of the device descriptor.
DEV_LEN, 18, device descriptor length in bytes.
CFG_OFS, 18, ROM offset of the full configuration descriptor set.
CFG_LEN, 32, total configuration descriptor length in bytes.

Ports:
clk_48  in  1  48 MHz core clock
rst  in  1  asynchronous reset, active-high
usb_rst  in  1  bus reset detected by the core
endpoint  in  4  endpoint of the current transaction
transaction_active  in  1  high for the duration of a token transaction
direction_in  in  1  1 = IN token
setup  in  1  1 = SETUP token
data_strobe  in  1  byte consumed (IN) or byte received (OUT)
success  in  1  transaction completed with good CRC / ACK
data_out  in  8  received byte
usb_address  out  7  device address to the core
handshake  out  2  00 ack, 01 none, 10 nak, 11 stall
data_toggle  out  1  PID toggle for the current data packet
data_in  out  8  byte to transmit
data_in_valid  out  1  more bytes remain in the current IN packet
desc_addr  out  ADDR_W  ROM read address; ROM has 1-cycle read latency
desc_data  in  8  ROM read data
cfg_value  out  8  current configuration value
configured  out  1  cfg_value != 0

Behaviour:
- Reset (rst, async): usb_address=0, handshake=ack, data_toggle=0, data_in=0, data_in_valid=0, desc_addr=0, cfg_value=0, configured=0, state=IDLE.
- usb_rst (synchronous): same values as reset except handshake, which holds.
- Input edge detection: transaction_active, data_strobe and success act on their rising edge only. All three are registered internally.
- States: IDLE, SETUP_RX, DATA_IN, STATUS_OUT, STATUS_IN, STALL.
- Non-zero endpoint: handshake=stall. ep0 state is unaffected.
- SETUP capture:
  - A SETUP token on ep0 is accepted in any state; it aborts the current transfer. Enter SETUP_RX with byte count=0 and handshake=ack.
  - Each strobe stores data_out at index count[2:0]; count saturates at 9.
  - On success with count==8: decode the request and set next toggle=1.
  - On success with count!=8, or transaction end without success: return to IDLE with no decode.
- GET_DESCRIPTOR (bmRequestType 0x80, bRequest 0x06):
  - wValue[15:8]=1 selects the device descriptor (DEV_OFS/DEV_LEN); =2 selects the configuration set (CFG_OFS/CFG_LEN); any other value goes to STALL.
  - Transfer length: xfer_len = min(wLength, LEN); ptr = OFS.
  - xfer_len==0 goes to STATUS_IN; otherwise DATA_IN.
- DATA_IN, on an IN token on ep0:
  - Packet size pkt = min(remaining, MAX_PKT).
  - data_in_valid asserts within 2 cycles of the transaction_active edge when pkt>0; data_in = ROM[ptr].
  - Each strobe increments desc_addr; the next byte is valid 1 cycle later, well before the next strobe (≥32 clocks).
  - data_in_valid drops on the cycle after the pkt-th strobe.
  - On success: ptr += pkt, remaining -= pkt, toggle flips.
  - Transaction end without success: no advance; the identical packet and toggle are resent on the next IN.
  - Stage complete when pkt < MAX_PKT. A ZLP is sent when remaining==0, pkt==MAX_PKT and xfer_len < wLength; otherwise stage complete when remaining==0.
  - On completion go to STATUS_OUT.
- An OUT token during DATA_IN or STATUS_OUT is the status stage:
  - ACK, with toggle=1 expected.
  - On success go to IDLE.
- SET_ADDRESS (0x00/0x05):
  - Latch wValue[6:0]; go to STATUS_IN.
  - usb_address updates only on success of the status IN ZLP (toggle=1), never earlier.
- SET_CONFIGURATION (0x00/0x09): cfg_value = wValue[7:0] on status-stage success.
- STATUS_IN: IN token sends a ZLP (data_in_valid stays 0) with toggle=1; on success go to IDLE.
- Any other request goes to STALL: handshake=stall for every ep0 IN/OUT token until the next SETUP. SETUP itself is always ACKed.
- In IDLE, ep0 IN/OUT tokens get handshake=nak.

Test Plan:
- GET_DESCRIPTOR device, wLength=64, MAX_PKT=64 → one 18-byte DATA1 packet matching ROM[0..17]; status OUT ACKed; state IDLE.
- GET_DESCRIPTOR config, CFG_LEN=32, MAX_PKT=8, wLength=255 → four 8-byte packets with toggles 1,0,1,0, then a ZLP with toggle 1; status OUT completes.
- Same with wLength=9 → packets of 8 and 1 bytes, no ZLP. Drop success on the 2nd packet → the 1-byte packet is resent with the same toggle.
- SET_ADDRESS wValue=0x2A → usb_address stays 0 through SETUP; becomes 0x2A only after the status ZLP succeeds.
- Unsupported request (bRequest 0x0A) → all ep0 tokens get stall; the following GET_DESCRIPTOR SETUP is ACKed and served normally.
- Assert rst mid DATA_IN, and separately usb_rst → outputs take reset values; configured=0; usb_address=0.

Source files
------------

// File: rtl/usb_ctrl_ep0_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_ctrl_ep0_if
// Purpose  : Transaction bus between the usb core (master) and the ep0 engine.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_ctrl_ep0_if;
  logic [3:0] endpoint;
  logic       transaction_active;
  logic       direction_in;
  logic       setup;
  logic       data_strobe;
  logic       success;
  logic [7:0] data_out;
  logic [6:0] usb_address;
  logic [1:0] handshake;
  logic       data_toggle;
  logic [7:0] data_in;
  logic       data_in_valid;

  modport master (
    output endpoint, transaction_active, direction_in, setup, data_strobe, success, data_out,
    input  usb_address, handshake, data_toggle, data_in, data_in_valid
  );

  modport slave (
    input  endpoint, transaction_active, direction_in, setup, data_strobe, success, data_out,
    output usb_address, handshake, data_toggle, data_in, data_in_valid
  );
endinterface
`default_nettype wire

// File: rtl/usb_ctrl_ep0.sv
`default_nettype none
// ============================================================================
// Module   : usb_ctrl_ep0
// Purpose  : Endpoint-0 control-transfer engine: SETUP decode, descriptor IN
//            data stages with toggle/ZLP handling, status stages.
// Revision : 1.0 - initial release
// ============================================================================
module usb_ctrl_ep0 #(
  parameter int MAX_PKT = 64,
  parameter int ADDR_W  = 7,
  parameter int DEV_OFS = 0,
  parameter int DEV_LEN = 18,
  parameter int CFG_OFS = 18,
  parameter int CFG_LEN = 32
) (
  input  wire               clk_48,
  input  wire               rst,
  input  wire               usb_rst,
  usb_ctrl_ep0_if.slave     bus,
  output logic [ADDR_W-1:0] desc_addr,
  input  wire  [7:0]        desc_data,
  output logic [7:0]        cfg_value,
  output logic              configured
);
  localparam logic [1:0] c_hs_ack   = 2'b00;
  localparam logic [1:0] c_hs_nak   = 2'b10;
  localparam logic [1:0] c_hs_stall = 2'b11;
  localparam logic [1:0] c_k_none   = 2'd0;
  localparam logic [1:0] c_k_setup  = 2'd1;
  localparam logic [1:0] c_k_data   = 2'd2;
  localparam logic [1:0] c_k_status = 2'd3;
  localparam logic [15:0]       c_max_pkt = 16'(MAX_PKT);
  localparam logic [15:0]       c_dev_len = 16'(DEV_LEN);
  localparam logic [15:0]       c_cfg_len = 16'(CFG_LEN);
  localparam logic [ADDR_W-1:0] c_dev_ofs = ADDR_W'(DEV_OFS);
  localparam logic [ADDR_W-1:0] c_cfg_ofs = ADDR_W'(CFG_OFS);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP_RX, S_DATA_IN, S_STATUS_OUT, S_STATUS_IN, S_STALL
  } state_t;

  state_t            r_state;
  logic [1:0]        r_kind;
  logic              r_ta, r_ta_q, r_ds, r_ds_q, r_su, r_su_q;
  logic [7:0]        r_dout;
  logic [3:0]        r_cnt;
  logic [7:0]        r_bm, r_breq;
  logic [15:0]       r_wval, r_wlen;
  logic [15:0]       r_xfer, r_rem, r_pkt, r_sent;
  logic [ADDR_W-1:0] r_ptr, r_daddr;
  logic [6:0]        r_addr, r_pend_addr;
  logic              r_addr_pend, r_cfg_pend;
  logic [7:0]        r_cfg, r_pend_cfg;
  logic              r_configured;
  logic [1:0]        r_hs;
  logic              r_toggle, r_valid;
  logic [7:0]        r_din;

  logic              w_ta_rise, w_ta_fall, w_ds_rise, w_su_rise, w_desc_ok;
  logic [15:0]       w_pkt, w_len, w_xfer, w_rem_next;
  logic [ADDR_W-1:0] w_ofs;

  assign w_ta_rise  = r_ta & ~r_ta_q;
  assign w_ta_fall  = ~r_ta & r_ta_q;
  assign w_ds_rise  = r_ds & ~r_ds_q;
  assign w_su_rise  = r_su & ~r_su_q;
  assign w_pkt      = (r_rem > c_max_pkt) ? c_max_pkt : r_rem;
  assign w_desc_ok  = (r_wval[15:8] == 8'd1) || (r_wval[15:8] == 8'd2);
  assign w_len      = (r_wval[15:8] == 8'd1) ? c_dev_len : c_cfg_len;
  assign w_ofs      = (r_wval[15:8] == 8'd1) ? c_dev_ofs : c_cfg_ofs;
  assign w_xfer     = (r_wlen < w_len) ? r_wlen : w_len;
  assign w_rem_next = r_rem - r_pkt;

  always_ff @(posedge clk_48 or posedge rst) begin
    if (rst) begin
      r_ta <= 1'b0; r_ta_q <= 1'b0; r_ds <= 1'b0; r_ds_q <= 1'b0;
      r_su <= 1'b0; r_su_q <= 1'b0; r_dout <= 8'h00;
      r_state <= S_IDLE; r_kind <= c_k_none; r_cnt <= 4'd0;
      r_bm <= 8'h00; r_breq <= 8'h00; r_wval <= 16'h0000; r_wlen <= 16'h0000;
      r_xfer <= 16'd0; r_rem <= 16'd0; r_pkt <= 16'd0; r_sent <= 16'd0;
      r_ptr <= '0; r_daddr <= '0;
      r_addr <= 7'd0; r_pend_addr <= 7'd0; r_addr_pend <= 1'b0;
      r_cfg <= 8'h00; r_pend_cfg <= 8'h00; r_cfg_pend <= 1'b0; r_configured <= 1'b0;
      r_hs <= c_hs_ack; r_toggle <= 1'b0; r_valid <= 1'b0; r_din <= 8'h00;
    end else begin
      r_ta <= bus.transaction_active; r_ta_q <= r_ta;
      r_ds <= bus.data_strobe;        r_ds_q <= r_ds;
      r_su <= bus.success;            r_su_q <= r_su;
      r_dout <= bus.data_out;
      if (usb_rst) begin
        r_state <= S_IDLE; r_kind <= c_k_none; r_cnt <= 4'd0;
        r_ptr <= '0; r_daddr <= '0; r_addr <= 7'd0; r_addr_pend <= 1'b0;
        r_cfg <= 8'h00; r_cfg_pend <= 1'b0; r_configured <= 1'b0;
        r_toggle <= 1'b0; r_valid <= 1'b0; r_din <= 8'h00;
      end else begin
        r_din <= (r_state == S_DATA_IN) ? desc_data : 8'h00;

        // Token start: choose the handshake and classify the transaction.
        if (w_ta_rise) begin
          if (bus.endpoint != 4'd0) begin
            r_hs <= c_hs_stall; r_kind <= c_k_none;
          end else if (bus.setup) begin
            r_state <= S_SETUP_RX; r_kind <= c_k_setup; r_cnt <= 4'd0;
            r_hs <= c_hs_ack; r_valid <= 1'b0;
            r_addr_pend <= 1'b0; r_cfg_pend <= 1'b0;
          end else if (r_state == S_STALL) begin
            r_hs <= c_hs_stall; r_kind <= c_k_none;
          end else if (bus.direction_in) begin
            case (r_state)
              S_DATA_IN: begin
                r_hs <= c_hs_ack; r_kind <= c_k_data; r_pkt <= w_pkt;
                r_sent <= 16'd0; r_valid <= (w_pkt != 16'd0); r_daddr <= r_ptr;
              end
              S_STATUS_IN: begin
                r_hs <= c_hs_ack; r_kind <= c_k_status; r_valid <= 1'b0; r_toggle <= 1'b1;
              end
              default: begin r_hs <= c_hs_nak; r_kind <= c_k_none; end
            endcase
          end else begin
            case (r_state)
              S_DATA_IN, S_STATUS_OUT: begin
                r_hs <= c_hs_ack; r_kind <= c_k_status; r_toggle <= 1'b1;
              end
              default: begin r_hs <= c_hs_nak; r_kind <= c_k_none; end
            endcase
          end
        end

        if (w_ds_rise) begin
          if (r_kind == c_k_setup) begin
            case (r_cnt[2:0])
              3'd0: r_bm          <= r_dout;
              3'd1: r_breq        <= r_dout;
              3'd2: r_wval[7:0]   <= r_dout;
              3'd3: r_wval[15:8]  <= r_dout;
              3'd6: r_wlen[7:0]   <= r_dout;
              3'd7: r_wlen[15:8]  <= r_dout;
              default: ;
            endcase
            if (r_cnt != 4'd9) r_cnt <= r_cnt + 4'd1;
          end else if (r_kind == c_k_data && r_valid) begin
            r_daddr <= r_daddr + 1'b1;
            r_sent  <= r_sent + 16'd1;
            if (r_sent + 16'd1 == r_pkt) r_valid <= 1'b0;
          end
        end

        if (w_su_rise) begin
          r_kind <= c_k_none;
          if (r_kind == c_k_setup) begin
            if (r_cnt == 4'd8) begin
              r_toggle <= 1'b1;
              if (r_bm == 8'h80 && r_breq == 8'h06) begin
                if (w_desc_ok) begin
                  r_xfer <= w_xfer; r_rem <= w_xfer; r_ptr <= w_ofs; r_daddr <= w_ofs;
                  r_state <= (w_xfer == 16'd0) ? S_STATUS_IN : S_DATA_IN;
                end else begin
                  r_state <= S_STALL;
                end
              end else if (r_bm == 8'h00 && r_breq == 8'h05) begin
                r_pend_addr <= r_wval[6:0]; r_addr_pend <= 1'b1; r_state <= S_STATUS_IN;
              end else if (r_bm == 8'h00 && r_breq == 8'h09) begin
                r_pend_cfg <= r_wval[7:0]; r_cfg_pend <= 1'b1; r_state <= S_STATUS_IN;
              end else begin
                r_state <= S_STALL;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_kind == c_k_data) begin
            r_valid  <= 1'b0;
            r_ptr    <= r_ptr + r_pkt[ADDR_W-1:0];
            r_daddr  <= r_ptr + r_pkt[ADDR_W-1:0];
            r_rem    <= w_rem_next;
            r_toggle <= ~r_toggle;
            // A full final packet needs a ZLP only when the host asked for more.
            if (r_pkt < c_max_pkt)
              r_state <= S_STATUS_OUT;
            else if (w_rem_next == 16'd0 && !(r_xfer < r_wlen))
              r_state <= S_STATUS_OUT;
          end else if (r_kind == c_k_status) begin
            r_state <= S_IDLE;
            if (r_state == S_STATUS_IN) begin
              if (r_addr_pend) r_addr <= r_pend_addr;
              if (r_cfg_pend) begin
                r_cfg        <= r_pend_cfg;
                r_configured <= (r_pend_cfg != 8'h00);
              end
            end
            r_addr_pend <= 1'b0; r_cfg_pend <= 1'b0;
          end
        end else if (w_ta_fall) begin
          // Transaction ended without success: rewind so the packet is resent.
          if (r_kind == c_k_setup) begin
            r_state <= S_IDLE;
          end else if (r_kind == c_k_data) begin
            r_valid <= 1'b0; r_daddr <= r_ptr;
          end
          r_kind <= c_k_none;
        end
      end
    end
  end

  assign bus.usb_address   = r_addr;
  assign bus.handshake     = r_hs;
  assign bus.data_toggle   = r_toggle;
  assign bus.data_in       = r_din;
  assign bus.data_in_valid = r_valid;
  assign desc_addr         = r_daddr;
  assign cfg_value         = r_cfg;
  assign configured        = r_configured;
endmodule
`default_nettype wire

// File: tb/tb_usb_ctrl_ep0.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_ctrl_ep0
// Purpose  : Directed bench for usb_ctrl_ep0 (MAX_PKT=64 and MAX_PKT=8 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_ctrl_ep0;
  logic       clk_48 = 1'b0;
  logic       rst = 1'b1;
  logic       usb_rst = 1'b0;
  logic [3:0] endpoint = 4'd0;
  logic       transaction_active = 1'b0, direction_in = 1'b0, setup = 1'b0;
  logic       data_strobe = 1'b0, success = 1'b0;
  logic [7:0] data_out = 8'h00;
  bit         sel = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  usb_ctrl_ep0_if bus64();
  usb_ctrl_ep0_if bus8();
  logic [6:0] da64, da8;
  logic [7:0] dd64 = 8'h00, dd8 = 8'h00, cfg64, cfg8;
  logic       conf64, conf8;

  assign bus64.endpoint = endpoint;            assign bus8.endpoint = endpoint;
  assign bus64.transaction_active = transaction_active;
  assign bus8.transaction_active  = transaction_active;
  assign bus64.direction_in = direction_in;    assign bus8.direction_in = direction_in;
  assign bus64.setup = setup;                  assign bus8.setup = setup;
  assign bus64.data_strobe = data_strobe;      assign bus8.data_strobe = data_strobe;
  assign bus64.success = success;              assign bus8.success = success;
  assign bus64.data_out = data_out;            assign bus8.data_out = data_out;

  usb_ctrl_ep0 #(.MAX_PKT(64)) u_dut64 (
    .clk_48(clk_48), .rst(rst), .usb_rst(usb_rst), .bus(bus64),
    .desc_addr(da64), .desc_data(dd64), .cfg_value(cfg64), .configured(conf64)
  );
  usb_ctrl_ep0 #(.MAX_PKT(8)) u_dut8 (
    .clk_48(clk_48), .rst(rst), .usb_rst(usb_rst), .bus(bus8),
    .desc_addr(da8), .desc_data(dd8), .cfg_value(cfg8), .configured(conf8)
  );

  logic [6:0] o_addr, o_daddr;
  logic [1:0] o_hs;
  logic       o_tog, o_valid, o_conf;
  logic [7:0] o_din, o_cfg;
  assign o_addr  = sel ? bus8.usb_address   : bus64.usb_address;
  assign o_hs    = sel ? bus8.handshake     : bus64.handshake;
  assign o_tog   = sel ? bus8.data_toggle   : bus64.data_toggle;
  assign o_din   = sel ? bus8.data_in       : bus64.data_in;
  assign o_valid = sel ? bus8.data_in_valid : bus64.data_in_valid;
  assign o_daddr = sel ? da8 : da64;
  assign o_cfg   = sel ? cfg8 : cfg64;
  assign o_conf  = sel ? conf8 : conf64;

  function automatic logic [7:0] rom_byte(input int a);
    return 8'(a * 37 + 11);
  endfunction

  always #5 clk_48 = ~clk_48;

  always @(posedge clk_48) begin
    dd64 <= rom_byte(int'(da64));
    dd8  <= rom_byte(int'(da8));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_48);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup_txn(input logic [63:0] req, input string tag);
    endpoint = 4'd0; setup = 1'b1; direction_in = 1'b0; transaction_active = 1'b1;
    cycles(3);
    check({tag, "_setup_hs"}, 16'(o_hs), 16'h0);
    for (int i = 0; i < 8; i++) begin
      data_out = req[63 - 8*i -: 8]; data_strobe = 1'b1; cycles(2);
      data_strobe = 1'b0; cycles(2);
    end
    success = 1'b1; cycles(2); success = 1'b0; cycles(1);
    transaction_active = 1'b0; setup = 1'b0; cycles(4);
  endtask

  task automatic in_txn(input int n, input logic tog, input int addr, input bit ok, input string tag);
    endpoint = 4'd0; direction_in = 1'b1; setup = 1'b0; transaction_active = 1'b1;
    cycles(3);
    check({tag, "_hs"}, 16'(o_hs), 16'h0);
    check({tag, "_tog"}, 16'(o_tog), 16'(tog));
    for (int i = 0; i < n; i++) begin
      check({tag, "_vld"}, 16'(o_valid), 16'h1);
      check({tag, "_byte"}, 16'(o_din), 16'(rom_byte(addr + i)));
      data_strobe = 1'b1; cycles(2); data_strobe = 1'b0; cycles(4);
    end
    check({tag, "_vld_end"}, 16'(o_valid), 16'h0);
    if (ok) begin success = 1'b1; cycles(2); success = 1'b0; cycles(1); end
    transaction_active = 1'b0; direction_in = 1'b0; cycles(5);
  endtask

  task automatic token(input logic [3:0] ep, input bit is_in, input logic [1:0] exp_hs,
                       input bit ok, input string tag);
    endpoint = ep; direction_in = is_in; setup = 1'b0; transaction_active = 1'b1;
    cycles(3);
    check({tag, "_hs"}, 16'(o_hs), 16'(exp_hs));
    if (!is_in && exp_hs == 2'b00) check({tag, "_tog"}, 16'(o_tog), 16'h1);
    if (ok) begin success = 1'b1; cycles(2); success = 1'b0; cycles(1); end
    transaction_active = 1'b0; direction_in = 1'b0; endpoint = 4'd0; cycles(5);
  endtask

  initial begin
    // Reset values
    cycles(2);
    check("rst_addr", 16'(o_addr), 16'h0);
    check("rst_hs", 16'(o_hs), 16'h0);
    check("rst_tog", 16'(o_tog), 16'h0);
    check("rst_valid", 16'(o_valid), 16'h0);
    check("rst_din", 16'(o_din), 16'h0);
    check("rst_daddr", 16'(o_daddr), 16'h0);
    check("rst_cfg", 16'(o_cfg), 16'h0);
    check("rst_conf", 16'(o_conf), 16'h0);
    rst = 1'b0; cycles(3);

    // Device descriptor, wLength=64, MAX_PKT=64: single 18-byte DATA1 packet
    sel = 1'b0;
    setup_txn(64'h8006_0001_0000_4000, "dev");
    in_txn(18, 1'b1, 0, 1'b1, "dev_in");
    token(4'd0, 1'b0, 2'b00, 1'b1, "dev_status");
    token(4'd0, 1'b1, 2'b10, 1'b0, "dev_idle");

    // Config set, MAX_PKT=8, wLength=255: 4x8 bytes then ZLP
    sel = 1'b1;
    setup_txn(64'h8006_0002_0000_FF00, "cfg");
    check("cfg_daddr", 16'(o_daddr), 16'd18);
    in_txn(8, 1'b1, 18, 1'b1, "cfg_p0");
    in_txn(8, 1'b0, 26, 1'b1, "cfg_p1");
    in_txn(8, 1'b1, 34, 1'b1, "cfg_p2");
    in_txn(8, 1'b0, 42, 1'b1, "cfg_p3");
    in_txn(0, 1'b1, 50, 1'b1, "cfg_zlp");
    token(4'd0, 1'b0, 2'b00, 1'b1, "cfg_status");
    token(4'd0, 1'b1, 2'b10, 1'b0, "cfg_idle");

    // wLength=9: 8 + 1 bytes, second packet retried after a lost ACK
    setup_txn(64'h8006_0002_0000_0900, "cfg9");
    in_txn(8, 1'b1, 18, 1'b1, "cfg9_p0");
    in_txn(1, 1'b0, 26, 1'b0, "cfg9_p1_lost");
    in_txn(1, 1'b0, 26, 1'b1, "cfg9_p1_retry");
    token(4'd0, 1'b0, 2'b00, 1'b1, "cfg9_status");
    token(4'd0, 1'b1, 2'b10, 1'b0, "cfg9_idle");

    // SET_ADDRESS 0x2A applied only after the status ZLP succeeds
    sel = 1'b0;
    setup_txn(64'h0005_2A00_0000_0000, "addr");
    check("addr_after_setup", 16'(o_addr), 16'h0);
    in_txn(0, 1'b1, 0, 1'b0, "addr_st_lost");
    check("addr_after_lost", 16'(o_addr), 16'h0);
    in_txn(0, 1'b1, 0, 1'b1, "addr_st");
    check("addr_applied", 16'(o_addr), 16'h2A);

    // SET_CONFIGURATION 3
    setup_txn(64'h0009_0300_0000_0000, "setcfg");
    check("cfg_before_status", 16'(o_cfg), 16'h0);
    in_txn(0, 1'b1, 0, 1'b1, "setcfg_st");
    check("cfg_value", 16'(o_cfg), 16'h3);
    check("cfg_conf", 16'(o_conf), 16'h1);
    check("cfg_addr_kept", 16'(o_addr), 16'h2A);

    // Unsupported request stalls until the next SETUP; other endpoints stall
    setup_txn(64'h000A_0000_0000_0000, "unsup");
    token(4'd0, 1'b1, 2'b11, 1'b0, "unsup_in");
    token(4'd0, 1'b0, 2'b11, 1'b0, "unsup_out");
    setup_txn(64'h8006_0001_0000_0800, "recov");
    token(4'd1, 1'b1, 2'b11, 1'b0, "ep1_in");
    in_txn(8, 1'b1, 0, 1'b1, "recov_in");
    token(4'd0, 1'b0, 2'b00, 1'b1, "recov_status");

    // Bus reset in the middle of an IN data packet
    setup_txn(64'h8006_0001_0000_4000, "ubr");
    endpoint = 4'd0; direction_in = 1'b1; transaction_active = 1'b1; cycles(3);
    for (int i = 0; i < 2; i++) begin
      data_strobe = 1'b1; cycles(2); data_strobe = 1'b0; cycles(4);
    end
    check("ubr_daddr_mid", 16'(o_daddr), 16'd2);
    usb_rst = 1'b1; cycles(2); usb_rst = 1'b0; cycles(1);
    check("ubr_valid", 16'(o_valid), 16'h0);
    check("ubr_din", 16'(o_din), 16'h0);
    check("ubr_daddr", 16'(o_daddr), 16'h0);
    check("ubr_addr", 16'(o_addr), 16'h0);
    check("ubr_cfg", 16'(o_cfg), 16'h0);
    check("ubr_conf", 16'(o_conf), 16'h0);
    check("ubr_tog", 16'(o_tog), 16'h0);
    check("ubr_hs_hold", 16'(o_hs), 16'h0);
    transaction_active = 1'b0; direction_in = 1'b0; cycles(5);
    token(4'd0, 1'b1, 2'b10, 1'b0, "ubr_idle");

    // Async reset in the middle of an IN data packet
    setup_txn(64'h0005_1500_0000_0000, "addr2");
    in_txn(0, 1'b1, 0, 1'b1, "addr2_st");
    setup_txn(64'h0009_0500_0000_0000, "cfg5");
    in_txn(0, 1'b1, 0, 1'b1, "cfg5_st");
    check("pre_rst_addr", 16'(o_addr), 16'h15);
    check("pre_rst_conf", 16'(o_conf), 16'h1);
    setup_txn(64'h8006_0001_0000_4000, "rstx");
    endpoint = 4'd0; direction_in = 1'b1; transaction_active = 1'b1; cycles(3);
    data_strobe = 1'b1; cycles(2); data_strobe = 1'b0; cycles(4);
    rst = 1'b1; cycles(1);
    check("arst_valid", 16'(o_valid), 16'h0);
    check("arst_din", 16'(o_din), 16'h0);
    check("arst_daddr", 16'(o_daddr), 16'h0);
    check("arst_addr", 16'(o_addr), 16'h0);
    check("arst_cfg", 16'(o_cfg), 16'h0);
    check("arst_conf", 16'(o_conf), 16'h0);
    check("arst_tog", 16'(o_tog), 16'h0);
    transaction_active = 1'b0; direction_in = 1'b0;
    cycles(2); rst = 1'b0; cycles(3);
    token(4'd0, 1'b1, 2'b10, 1'b0, "arst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
